keypad_emu: RTL and testbench

Synthesizable 4×4 keypad matrix emulator: the responder end of the column-scan/row-sense keypad interface. It takes key-press requests over a req/ack handshake and drives active-low row lines in response to the scanner's active-low column drive, with optional contact bounce, so the keypad scanner, processor and display path can be exercised in loopback without a physical keypad. It sits between a self-test source and the scanner's `row`/`col` pins.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_emu.sv | 180 ++++++++++++++++++
 tb/tb_keypad_emu.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared constants for the 4x4 keypad matrix emulator:
//                FSM state encoding, key-code field slices, idle line
//                level and the active-low row decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Key code layout: {row[1:0], col[1:0]}
  localparam int KEY_W  = 4;
  localparam int ROW_HI = 3;
  localparam int ROW_LO = 2;
  localparam int COL_HI = 1;
  localparam int COL_LO = 0;

  // Row/column lines are active-low; all-high means nothing pressed.
  localparam logic [3:0] LINES_IDLE = 4'hF;

  // Press/release sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_BOUNCE_IN  = 3'd1;
  localparam state_t ST_HOLD       = 3'd2;
  localparam state_t ST_BOUNCE_OUT = 3'd3;
  localparam state_t ST_GAP        = 3'd4;

  // A closed contact at (row, col) pulls its row low only while the
  // scanner is driving that column low; every other column is ignored.
  function automatic logic [3:0] row_decode(input logic             contact,
                                            input logic [KEY_W-1:0] key,
                                            input logic [3:0]       col);
    logic [3:0] rows;
    rows = LINES_IDLE;
    if (contact && !col[key[COL_HI:COL_LO]]) begin
      rows[key[ROW_HI:ROW_LO]] = 1'b0;
    end
    return rows;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emu
//  Description : Responder end of a column-scan / row-sense 4x4 keypad.
//                Accepts key-press requests over req/ack, then plays a
//                bounce-in / hold / bounce-out / gap contact sequence and
//                drives the active-low rows from the scanner's column drive.
//  Ports       : i_clk, i_rst_n (sync, active-low)
//                i_col  [3:0]  column drive from scanner (active-low)
//                o_row  [3:0]  row sense to scanner (active-low, idle 4'hF)
//                i_req/o_ack   press request handshake (ack = 1-cycle pulse)
//                i_key  [3:0]  {row, col} of the key, sampled on accept
//                i_hold        closed-contact cycles, 0 treated as 1
//                o_busy        sequence in progress
//                o_done        1-cycle pulse at the end of the sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_emu
  import keypad_pkg::*;
#(
  parameter int HOLD_W     = 16,
  parameter int BOUNCE_N   = 2,
  parameter int BOUNCE_CYC = 4,
  parameter int GAP_CYC    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_col,
  output logic [3:0]        o_row,
  input  logic              i_req,
  input  logic [3:0]        i_key,
  input  logic [HOLD_W-1:0] i_hold,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_done
);

  // Counter widths are kept at least one bit so degenerate parameter
  // values (BOUNCE_CYC=1, BOUNCE_N=0) still elaborate cleanly.
  localparam int SLOT_W = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam int IDX_W  = (BOUNCE_N > 0) ? $clog2(2 * BOUNCE_N) : 1;
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  // The hold counter also times the gap, so it must fit GAP_CYC too.
  localparam int CNT_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(BOUNCE_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'((BOUNCE_N > 0) ? (2 * BOUNCE_N - 1) : 0);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYC);
  localparam bit                HAS_BOUNCE = (BOUNCE_N > 0);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [SLOT_W-1:0]  slot_q,  slot_d;   // cycle within a bounce slot
  logic [IDX_W-1:0]   idx_q,   idx_d;    // bounce slot index
  logic [CNT_W-1:0]   cnt_q,   cnt_d;    // hold / gap down-counter
  logic               ack_q,   ack_d;
  logic               done_q,  done_d;
  logic               contact;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          key_d   = i_key;
          // The counter is loaded with the hold length directly, so the
          // request's hold value is latched here and never looked at again.
          cnt_d   = (i_hold == '0) ? CNT_ONE : CNT_W'(i_hold);
          slot_d  = '0;
          idx_d   = '0;
          ack_d   = 1'b1;
          state_d = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
        end
      end

      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (state_q == ST_BOUNCE_IN) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          slot_d = slot_q + SLOT_ONE;
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_ONE) begin
          if (HAS_BOUNCE) begin
            state_d = ST_BOUNCE_OUT;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Contact level: bounce-in starts closed on even slots, bounce-out starts
  // open on even slots, so both edges of the press chatter symmetrically.
  // --------------------------------------------------------------------------
  always_comb begin
    contact = 1'b0;
    case (state_q)
      ST_BOUNCE_IN:  contact = ~idx_q[0];
      ST_HOLD:       contact = 1'b1;
      ST_BOUNCE_OUT: contact = idx_q[0];
      default:       contact = 1'b0;
    endcase
  end

  assign o_row  = row_decode(contact, key_q, i_col);
  assign o_ack  = ack_q;
  assign o_done = done_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_emu
//  Description : Self-checking bench for keypad_emu. Two instances: one
//                without bounce (index 0) and one with the default bounce
//                settings (index 1). Each press pushes its full expected
//                per-cycle trace into a scoreboard queue which is popped and
//                compared as the DUT runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emu;

  localparam int HOLD_W = 16;
  localparam int CYC    = 4;
  localparam int GAP    = 8;

  typedef struct packed {
    logic [3:0] row;
    logic       ack;
    logic       busy;
    logic       done;
  } exp_t;

  logic              clk;
  logic              rst_n  [2];
  logic [3:0]        col    [2];
  logic [3:0]        row    [2];
  logic              req    [2];
  logic [3:0]        key    [2];
  logic [HOLD_W-1:0] hold   [2];
  logic              ack    [2];
  logic              busy   [2];
  logic              done   [2];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  keypad_emu #(.HOLD_W(HOLD_W), .BOUNCE_N(0), .BOUNCE_CYC(CYC), .GAP_CYC(GAP)) u_dut0 (
    .i_clk  (clk),      .i_rst_n(rst_n[0]), .i_col (col[0]),  .o_row (row[0]),
    .i_req  (req[0]),   .i_key  (key[0]),   .i_hold(hold[0]), .o_ack (ack[0]),
    .o_busy (busy[0]),  .o_done (done[0])
  );

  keypad_emu #(.HOLD_W(HOLD_W), .BOUNCE_N(2), .BOUNCE_CYC(CYC), .GAP_CYC(GAP)) u_dut1 (
    .i_clk  (clk),      .i_rst_n(rst_n[1]), .i_col (col[1]),  .o_row (row[1]),
    .i_req  (req[1]),   .i_key  (key[1]),   .i_hold(hold[1]), .o_ack (ack[1]),
    .o_busy (busy[1]),  .o_done (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_row(input bit c, input logic [3:0] k, input logic [3:0] cl);
    logic [3:0] r;
    r = 4'hF;
    if (c && cl[k[1:0]] == 1'b0) r[k[3:2]] = 1'b0;
    return r;
  endfunction

  // Builds the expected trace from the first post-acceptance cycle up to
  // and including the o_done cycle.
  task automatic push_trace(input int bn, input logic [3:0] k, input int hc, input logic [3:0] cl);
    exp_t e;
    bit   first;
    first = 1'b1;
    for (int s = 0; s < 2 * bn; s++)
      for (int c = 0; c < CYC; c++) begin
        e = '{row: exp_row((s % 2) == 0, k, cl), ack: first, busy: 1'b1, done: 1'b0};
        sb_q.push_back(e); first = 1'b0;
      end
    for (int h = 0; h < hc; h++) begin
      e = '{row: exp_row(1'b1, k, cl), ack: first, busy: 1'b1, done: 1'b0};
      sb_q.push_back(e); first = 1'b0;
    end
    for (int s = 0; s < 2 * bn; s++)
      for (int c = 0; c < CYC; c++) begin
        e = '{row: exp_row((s % 2) == 1, k, cl), ack: 1'b0, busy: 1'b1, done: 1'b0};
        sb_q.push_back(e);
      end
    for (int g = 0; g < GAP; g++) begin
      e = '{row: 4'hF, ack: 1'b0, busy: 1'b1, done: 1'b0};
      sb_q.push_back(e);
    end
    e = '{row: 4'hF, ack: 1'b0, busy: 1'b0, done: 1'b1};
    sb_q.push_back(e);
  endtask

  // One full press on instance d. With poke set, i_req is pulsed while the
  // sequence is running and must be ignored. Key/hold are scrambled right
  // after acceptance and must not matter.
  task automatic press(input int d, input logic [3:0] k, input logic [15:0] h,
                       input logic [3:0] cl, input bit poke);
    exp_t e;
    int   t, i, hc;
    hc = (h == 16'd0) ? 1 : int'(h);
    @(posedge clk); #1;
    req[d] = 1'b1; key[d] = k; hold[d] = h; col[d] = cl;
    push_trace((d == 0) ? 0 : 2, k, hc, cl);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack[d] && t < 20);
    if (!ack[d]) begin
      check("ack_timeout", 32'(ack[d]), 32'd1);
      req[d] = 1'b0;
      sb_q.delete();
      return;
    end
    req[d]  = 1'b0;
    key[d]  = 4'(~k);
    hold[d] = 16'(h + 16'd7);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("d%0d_k%0h_row@%0d", d, k, i), 32'(row[d]),  32'(e.row));
      check($sformatf("d%0d_k%0h_ack@%0d", d, k, i), 32'(ack[d]),  32'(e.ack));
      check($sformatf("d%0d_k%0h_bsy@%0d", d, k, i), 32'(busy[d]), 32'(e.busy));
      check($sformatf("d%0d_k%0h_dne@%0d", d, k, i), 32'(done[d]), 32'(e.done));
      if (poke && i == 3) req[d] = 1'b1;
      if (poke && i == 4) req[d] = 1'b0;
      i++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [3:0] k, cl;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b1; col[d] = 4'h0; key[d] = 4'h0; hold[d] = '0;
    end

    // Reset with a pending request: nothing may leak out.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_row%0d", d),  32'(row[d]),  32'hF);
      check($sformatf("rst_ack%0d", d),  32'(ack[d]),  32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
      req[d] = 1'b0;
      rst_n[d] = 1'b1;
    end
    col[0] = 4'hF; col[1] = 4'hF;

    // No bounce: key 6 (row 1, col 2), column 2 driven low.
    press(0, 4'h6, 16'd10, 4'b1011, 1'b0);
    // Wrong column driven: rows stay idle.
    press(0, 4'h6, 16'd10, 4'b1101, 1'b0);
    // hold=0 behaves as one cycle; req pulsed while busy.
    press(0, 4'h9, 16'd0, 4'b0000, 1'b1);
    press(0, 4'hF, 16'd1, 4'b0111, 1'b1);

    // Bounce on both edges, key 0 with every column low.
    press(1, 4'h0, 16'd5, 4'h0, 1'b1);
    press(1, 4'hA, 16'd0, 4'b1011, 1'b0);

    // All keys through the bounced instance, random column drive.
    for (int n = 0; n < 16; n++) begin
      k  = 4'(n);
      cl = 4'($urandom_range(0, 15));
      if (n % 2 == 0) cl[k[1:0]] = 1'b0;
      press(1, k, 16'($urandom_range(0, 4)), cl, 1'b0);
    end

    // Reset in the middle of HOLD aborts with no o_done.
    @(posedge clk); #1;
    req[0] = 1'b1; key[0] = 4'h5; hold[0] = 16'd10; col[0] = 4'b1101;
    dones = 0;
    do begin
      @(negedge clk);
      dones++;
    end while (!ack[0] && dones < 20);
    check("midrst_ack", 32'(ack[0]), 32'd1);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_hold_row", 32'(row[0]), 32'hD);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midrst_row",  32'(row[0]),  32'hF);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_ack0", 32'(ack[0]),  32'd0);
    rst_n[0] = 1'b1;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done[0] || busy[0]) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    press(0, 4'h5, 16'd3, 4'b1101, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
